// File: rtl/read_mem_burst.sv
// Burst read engine: LEN consecutive words, credit-limited issue, response FIFO; READ_MEM_BURST_ERR_EN adds error responses.
// Push to rvalid_o takes 1 cycle; rready_i low holds the FIFO and, via credits, throttles new requests.
module read_mem_burst #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              mem_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_req_last_o,
  input  logic              mem_ready_i,
`ifdef READ_MEM_BURST_ERR_EN
  input  logic              mem_result_err_i,
  output logic              err_o,
`endif
  input  logic              mem_result_valid_i,
  input  logic [DATA_W-1:0] mem_result_rdata_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  req_left, resp_left;
  logic [CW-1:0]     outstanding, fifo_count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic credit_ok, req_acc, resp_vld, resp_err, err_q;
  logic push, pop, flush, start_acc, drain_done;

  // Buffered words plus in-flight requests never exceed the FIFO depth.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH);

  assign mem_valid_o    = (state_q == S_ISSUE) && (req_left != '0) && credit_ok;
  assign mem_addr_o     = addr_q;
  assign mem_req_last_o = mem_valid_o && (req_left == LEN_W'(1));
  assign req_acc        = mem_valid_o && mem_ready_i;

  assign resp_vld = mem_result_valid_i && (outstanding != '0) &&
                    ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign push     = resp_vld && !resp_err && !err_q;
  assign pop      = rvalid_o && rready_i;

  assign rvalid_o = (fifo_count != '0);
  assign rdata_o  = rvalid_o ? fifo_mem[rd_ptr] : '0;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);

  assign drain_done = (resp_left == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

`ifdef READ_MEM_BURST_ERR_EN
  assign resp_err = resp_vld && mem_result_err_i;
  assign err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)        err_q <= 1'b0;
    else if (start_acc) err_q <= 1'b0;
    else if (resp_err)  err_q <= 1'b1;
  end
`else
  assign resp_err = 1'b0;
  assign err_q    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = (len_i != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if ((req_acc && (req_left == LEN_W'(1))) || resp_err) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // After an error, wait only for in-flight responses, then discard what is buffered.
        if (err_q) begin
          if (outstanding == '0) begin
            flush   = 1'b1;
            state_d = S_DONE;
          end
        end else if (drain_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      req_left    <= '0;
      resp_left   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q <= state_d;

      if (start_acc) begin
        addr_q    <= addr_i;
        req_left  <= len_i;
        resp_left <= len_i;
      end else begin
        if (req_acc) begin
          addr_q   <= addr_q + STEP;
          req_left <= req_left - LEN_W'(1);
        end
        if (resp_err) req_left <= '0;
        if (resp_vld) resp_left <= resp_left - LEN_W'(1);
      end

      unique case ({req_acc, resp_vld})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (flush) begin
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= mem_result_rdata_i;
  end

  // A pop in the same cycle frees the slot being written.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_read_mem_burst.sv
// Directed bench for read_mem_burst with a 1-cycle-response memory model and a logging consumer.
module tb_read_mem_burst;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] addr_i;
  logic [4:0]  len_i;
  logic        busy_o, done_o, rvalid_o, rready_i;
  logic [31:0] rdata_o;
  logic        mem_valid_o, mem_req_last_o, mem_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_result_valid_i;
  logic [31:0] mem_result_rdata_i;
`ifdef READ_MEM_BURST_ERR_EN
  logic        mem_result_err_i;
  logic        err_o;
  int          err_idx = -1;
  int          resp_cnt = 0;
`endif

  read_mem_burst dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_req_last_o(mem_req_last_o),
    .mem_ready_i(mem_ready_i),
`ifdef READ_MEM_BURST_ERR_EN
    .mem_result_err_i(mem_result_err_i), .err_o(err_o),
`endif
    .mem_result_valid_i(mem_result_valid_i), .mem_result_rdata_i(mem_result_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_done = 0;
  logic resp_en = 1'b1;
  logic inject = 1'b0;

  logic [31:0] acc_addr[$];
  logic        acc_last[$];
  int          acc_cyc[$];
  logic [31:0] got[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_last.delete(); acc_cyc.delete(); got.delete(); n_done = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done_o; i++) step();
    chk(tag, 64'(done_o), 64'd1);
  endtask

  task automatic start_burst(input logic [31:0] a, input logic [4:0] l);
    start_i = 1'b1; addr_i = a; len_i = l;
    step();
    start_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    chk({tag, "_mvalid"}, 64'(mem_valid_o), 64'd0);
    chk({tag, "_mlast"}, 64'(mem_req_last_o), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata_o), 64'd0);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory: accepts sampled mid-cycle, response driven for the following cycle.
  initial begin
    logic acc, en, inj;
    logic [31:0] a;
    mem_result_valid_i = 1'b0;
    mem_result_rdata_i = '0;
`ifdef READ_MEM_BURST_ERR_EN
    mem_result_err_i = 1'b0;
`endif
    forever begin
      @(negedge clk_i);
      acc = mem_valid_o && mem_ready_i;
      a   = mem_addr_o;
      en  = resp_en;
      inj = inject;
      if (acc) begin
        acc_addr.push_back(a); acc_last.push_back(mem_req_last_o); acc_cyc.push_back(cyc);
      end
      @(posedge clk_i);
      #1;
      mem_result_valid_i = (acc && en) || inj;
      mem_result_rdata_i = dat(a);
`ifdef READ_MEM_BURST_ERR_EN
      mem_result_err_i = (acc && en) && (resp_cnt == err_idx);
      if (acc && en) resp_cnt++;
`endif
    end
  end

  always @(negedge clk_i) begin
    if (rvalid_o && rready_i) got.push_back(rdata_o);
    if (done_o) n_done++;
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; addr_i = '0; len_i = '0;
    rready_i = 1'b1; mem_ready_i = 1'b1;
    step(); step();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    step();

    // Basic 4-word burst
    clear_logs();
    start_burst(32'h100, 5'd4);
    chk("basic_first_valid", 64'(mem_valid_o), 64'd1);
    chk("basic_first_addr", 64'(mem_addr_o), 64'h100);
    chk("basic_busy", 64'(busy_o), 64'd1);
    wait_done("basic_done_seen", 40);
    step();
    chk("basic_done_one_cycle", 64'(done_o), 64'd0);
    chk("basic_idle", 64'(busy_o), 64'd0);
    chk("basic_n_req", 64'(acc_addr.size()), 64'd4);
    chk("basic_n_words", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_addr.size() && i < got.size(); i++) begin
      chk($sformatf("basic_addr%0d", i), 64'(acc_addr[i]), 64'(32'h100 + 32'(4 * i)));
      chk($sformatf("basic_last%0d", i), 64'(acc_last[i]), 64'(i == 3));
      chk($sformatf("basic_cyc%0d", i), 64'(acc_cyc[i] - acc_cyc[0]), 64'(i));
      chk($sformatf("basic_data%0d", i), 64'(got[i]), 64'(dat(32'h100 + 32'(4 * i))));
    end
    chk("basic_n_done", 64'(n_done), 64'd1);

    // Back-pressure: consumer stalled, credits cap requests at the FIFO depth
    clear_logs();
    rready_i = 1'b0;
    start_burst(32'h200, 5'd8);
    for (int i = 0; i < 20; i++) step();
    chk("bp_n_req", 64'(acc_addr.size()), 64'd4);
    chk("bp_rvalid", 64'(rvalid_o), 64'd1);
    chk("bp_no_req", 64'(mem_valid_o), 64'd0);
    chk("bp_head", 64'(rdata_o), 64'(dat(32'h200)));
    rready_i = 1'b1;
    wait_done("bp_done_seen", 60);
    step();
    chk("bp_n_words", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("bp_data%0d", i), 64'(got[i]), 64'(dat(32'h200 + 32'(4 * i))));

    // Zero length
    clear_logs();
    start_burst(32'h300, 5'd0);
    chk("zero_done", 64'(done_o), 64'd1);
    chk("zero_busy", 64'(busy_o), 64'd1);
    chk("zero_no_req", 64'(mem_valid_o), 64'd0);
    step();
    chk("zero_done_cleared", 64'(done_o), 64'd0);
    chk("zero_idle", 64'(busy_o), 64'd0);
    chk("zero_n_req", 64'(acc_addr.size()), 64'd0);

    // Address wrap with memory stall
    clear_logs();
    mem_ready_i = 1'b0;
    start_burst(32'hFFFF_FFFC, 5'd2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_hold_valid%0d", i), 64'(mem_valid_o), 64'd1);
      chk($sformatf("wrap_hold_addr%0d", i), 64'(mem_addr_o), 64'hFFFF_FFFC);
      if (i < 2) step();
    end
    mem_ready_i = 1'b1;
    step();
    chk("wrap_addr", 64'(mem_addr_o), 64'h0);
    chk("wrap_last", 64'(mem_req_last_o), 64'd1);
    wait_done("wrap_done_seen", 30);
    step();
    chk("wrap_n_words", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("wrap_data0", 64'(got[0]), 64'(dat(32'hFFFF_FFFC)));
      chk("wrap_data1", 64'(got[1]), 64'(dat(32'h0)));
    end

    // Reset mid-burst with two requests outstanding, then a late response
    clear_logs();
    resp_en = 1'b0;
    start_burst(32'h300, 5'd4);
    step(); step();
    chk("rst_mid_issue", 64'(mem_valid_o), 64'd1);
    chk("rst_mid_n_req", 64'(acc_addr.size()), 64'd2);
    rst_ni = 1'b0; mem_ready_i = 1'b0;
    step();
    chk_all_zero("rst_mid");
    rst_ni = 1'b1;
    inject = 1'b1;
    step();
    inject = 1'b0;
    step(); step();
    chk("rst_late_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_late_busy", 64'(busy_o), 64'd0);
    clear_logs();
    resp_en = 1'b1; mem_ready_i = 1'b1;
    start_burst(32'h400, 5'd1);
    wait_done("rst_after_done_seen", 30);
    step();
    chk("rst_after_n_req", 64'(acc_addr.size()), 64'd1);
    chk("rst_after_n_words", 64'(got.size()), 64'd1);
    if (got.size() == 1) chk("rst_after_data", 64'(got[0]), 64'(dat(32'h400)));

`ifdef READ_MEM_BURST_ERR_EN
    // Error on the second response of a 4-word burst
    clear_logs();
    resp_cnt = 0; err_idx = 1;
    start_burst(32'h500, 5'd4);
    wait_done("err_done_seen", 40);
    chk("err_flag_at_done", 64'(err_o), 64'd1);
    step();
    chk("err_sticky", 64'(err_o), 64'd1);
    chk("err_words_le1", 64'(got.size() <= 1), 64'd1);
    chk("err_reqs_le3", 64'(acc_addr.size() <= 3), 64'd1);
    chk("err_fifo_flushed", 64'(rvalid_o), 64'd0);
    err_idx = -1;
    start_burst(32'h600, 5'd1);
    chk("err_cleared_on_start", 64'(err_o), 64'd0);
    wait_done("err_next_done_seen", 30);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
